// File: rtl/dmem_arbiter.sv
// Data-memory sequencer: arbitrates the single DATAMEM port between the MEM-stage
// load/store and the external loader, holding each access for MEM_LAT cycles.
module dmem_arbiter #(
    parameter int MEM_LAT    = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  PipeMemRead,
    input  logic                                  PipeMemWrite,
    input  logic [31:0]                           PipeAddr,
    input  logic [31:0]                           PipeWdata,
    output logic [31:0]                           PipeRdata,
    output logic                                  PipeStall,
    input  logic                                  LdReq,
    input  logic                                  LdWe,
    input  logic [31:0]                           LdAddr,
    input  logic [31:0]                           LdWdata,
    output logic                                  LdGnt,
    output logic                                  LdValid,
    output logic [31:0]                           LdRdata,
    output logic                                  MemRead,
    output logic                                  MemWrite,
    output logic [31:0]                           MemAddr,
    output logic [31:0]                           MemWdata,
    input  logic [31:0]                           MemRdata,
    output logic [1:0]                            dbg_state,
    output logic                                  dbg_owner,
    output logic [$clog2(STARVE_MAX+1)-1:0]       dbg_starve_cnt
);

    // Handshake: the loader raises LdReq with stable LdWe/LdAddr/LdWdata and keeps them
    // until the cycle LdGnt is high (request consumed at that edge); LdValid pulses once
    // when the granted access completes. The pipeline is held by PipeStall instead.

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic {
        OWN_PIPE = 1'b0,
        OWN_LD   = 1'b1
    } owner_t;

    state_t          state, state_d;
    owner_t          owner, owner_d;
    logic [CW-1:0]   cnt, cnt_d;
    logic [SW-1:0]   starve_cnt, starve_d;
    logic            mem_read_d, mem_write_d;
    logic [31:0]     mem_addr_d, mem_wdata_d;
    logic [31:0]     pipe_rdata_d, ld_rdata_d;
    logic            pipe_req;
    logic            grant_ld;

    assign pipe_req = PipeMemRead | PipeMemWrite;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            owner      <= OWN_PIPE;
            cnt        <= '0;
            starve_cnt <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            MemAddr    <= '0;
            MemWdata   <= '0;
            PipeRdata  <= '0;
            LdRdata    <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            cnt        <= cnt_d;
            starve_cnt <= starve_d;
            MemRead    <= mem_read_d;
            MemWrite   <= mem_write_d;
            MemAddr    <= mem_addr_d;
            MemWdata   <= mem_wdata_d;
            PipeRdata  <= pipe_rdata_d;
            LdRdata    <= ld_rdata_d;
        end
    end

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        cnt_d        = cnt;
        starve_d     = starve_cnt;
        mem_read_d   = MemRead;
        mem_write_d  = MemWrite;
        mem_addr_d   = MemAddr;
        mem_wdata_d  = MemWdata;
        pipe_rdata_d = PipeRdata;
        ld_rdata_d   = LdRdata;
        grant_ld     = 1'b0;

        case (state)
            IDLE: begin
                // Pipeline has priority unless idle or it has starved the loader.
                grant_ld = LdReq & (~pipe_req | (starve_cnt == SW'(STARVE_MAX)));
                if (grant_ld) begin
                    owner_d     = OWN_LD;
                    mem_read_d  = ~LdWe;
                    mem_write_d = LdWe;
                    mem_addr_d  = LdAddr;
                    mem_wdata_d = LdWdata;
                    starve_d    = '0;
                    cnt_d       = '0;
                    state_d     = BUSY;
                end else if (pipe_req) begin
                    owner_d     = OWN_PIPE;
                    mem_read_d  = ~PipeMemWrite;
                    mem_write_d = PipeMemWrite;
                    mem_addr_d  = PipeAddr;
                    mem_wdata_d = PipeWdata;
                    cnt_d       = '0;
                    state_d     = BUSY;
                    if (!LdReq)
                        starve_d = '0;
                    else if (starve_cnt != SW'(STARVE_MAX))
                        starve_d = starve_cnt + SW'(1);
                end
            end
            BUSY: begin
                cnt_d = cnt + CW'(1);
                if (cnt == CW'(MEM_LAT - 1)) begin
                    if (MemRead) begin
                        if (owner == OWN_LD)
                            ld_rdata_d = MemRdata;
                        else
                            pipe_rdata_d = MemRdata;
                    end
                    mem_read_d  = 1'b0;
                    mem_write_d = 1'b0;
                    state_d     = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Gated by rst_n so nothing combinational leaks out while reset is asserted.
    assign LdGnt     = rst_n & grant_ld;
    assign PipeStall = rst_n & pipe_req & ((state != DONE) | (owner != OWN_PIPE));
    assign LdValid   = (state == DONE) & (owner == OWN_LD);

    assign dbg_state      = state;
    assign dbg_owner      = owner;
    assign dbg_starve_cnt = starve_cnt;

endmodule

// File: doc/dmem_arbiter.md
# dmem_arbiter

Sequencing controller and two-way arbiter for the data memory in the MEM stage. It shares the single DATAMEM port between the pipeline's MEM-stage load/store and an external loader/debug port. It drives multi-cycle memory accesses and stalls the pipeline until its access completes. A starvation guard guarantees the loader forward progress while the pipeline issues back-to-back memory ops.

## Interface
- MEM_LAT, 2: cycles the memory signals are held per access (≥1)
- STARVE_MAX, 4: consecutive pipeline grants allowed while the loader waits (≥1)
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- PipeMemRead  in  1  pipeline load request (MEM[2])
- PipeMemWrite  in  1  pipeline store request (MEM[1])
- PipeAddr  in  32  pipeline address (ALU result)
- PipeWdata  in  32  pipeline store data (B)
- PipeRdata  out  32  registered load data to MEM/WB
- PipeStall  out  1  freeze PC/IF/ID/EX/MEM registers
- LdReq  in  1  loader request, held until LdGnt
- LdWe  in  1  loader write (1) / read (0)
- LdAddr  in  32  loader address
- LdWdata  in  32  loader write data
- LdGnt  out  1  one-cycle pulse, loader request accepted
- LdValid  out  1  one-cycle pulse, loader access complete
- LdRdata  out  32  registered loader read data
- MemRead, MemWrite  out  1  to DATAMEM
- MemAddr, MemWdata  out  32  to DATAMEM
- MemRdata  in  32  from DATAMEM

## Operation
- Pipeline request = PipeMemRead | PipeMemWrite. If both are set, the access is treated as a write and MemRead stays 0.
- FSM states: IDLE, BUSY, DONE. An owner register records PIPE or LD.
- IDLE: if any request is pending, grant at the clock edge. The edge latches owner, op, address and write data into the Mem* registers, clears cnt, and moves to BUSY. LdGnt is high in the IDLE cycle in which the loader wins.
- Arbitration: the pipeline wins by default. The loader wins if the pipeline is idle, or if starve_cnt == STARVE_MAX while both are requesting.
- starve_cnt, 0..STARVE_MAX, saturating:
  - increments on a pipeline grant while LdReq=1
  - clears on a loader grant, or on a pipeline grant with LdReq=0
- BUSY: MemRead/MemWrite/MemAddr/MemWdata are held stable and cnt increments each cycle. When cnt == MEM_LAT-1, the edge captures MemRdata for reads, into PipeRdata or LdRdata by owner. The same edge drops MemRead/MemWrite to 0 and moves to DONE.
- DONE: one cycle, then IDLE unconditionally. No grant is issued in DONE.
- Write completion does not modify PipeRdata or LdRdata.
- PipeStall (combinational) = pipeline request & (state != DONE | owner != PIPE). The pipeline is therefore also stalled while the loader owns memory.
- LdValid = (state == DONE) & (owner == LD).
- The loader must hold LdReq, LdWe, LdAddr and LdWdata stable until LdGnt. It drops or changes LdReq after LdGnt. Behaviour with LdReq still high in the following IDLE is a new request.
- Pipeline inputs are stable while PipeStall=1, because the pipeline is frozen.

## Timing
- Pipeline access latency: request seen in IDLE cycle T, BUSY T+1..T+MEM_LAT, DONE T+MEM_LAT+1.
  - PipeStall is high T..T+MEM_LAT and low in DONE.
  - MEM/WB latches PipeRdata at the end of DONE.
- Loader access: LdGnt at T, LdValid at T+MEM_LAT+1, with LdRdata valid in the same cycle and held until the next loader read completes.
- Minimum request-to-request period is MEM_LAT+2 cycles.
- Reset (any time, including mid-access):
  - state=IDLE, owner=PIPE, cnt=0, starve_cnt=0
  - MemRead=MemWrite=0, MemAddr=MemWdata=0, PipeRdata=LdRdata=0, LdGnt=LdValid=0, PipeStall=0
  - the in-flight access is abandoned with no completion pulse
- Memory outputs change only at the clock edge or on reset assertion. There are no combinational paths from requests to Mem* outputs.

## Test plan
- Pipeline load, MEM_LAT=2: PipeMemRead=1, PipeAddr=0x10, memory word=0xDEADBEEF.
  - MemRead high exactly 2 cycles with MemAddr=0x10.
  - PipeStall high 3 cycles; PipeRdata=0xDEADBEEF in DONE.
- Pipeline store with both PipeMemRead and PipeMemWrite set, Addr 0x20, Wdata 0x1234.
  - MemWrite high 2 cycles, MemRead never high, PipeRdata unchanged.
  - A subsequent loader read of 0x20 returns LdRdata=0x1234.
- Simultaneous LdReq and pipeline request in IDLE, starve_cnt=0: pipeline is granted first and LdGnt stays 0. The loader is granted in the next IDLE only if the pipeline is idle.
- Starvation, STARVE_MAX=4: the pipeline issues continuous loads while LdReq is held high. Exactly 4 pipeline accesses complete, then LdGnt pulses and PipeStall stays high through the loader access (4 cycles). starve_cnt then returns to 0.
- Reset mid-BUSY during a loader write: deassert rst_n at cnt=0.
  - All outputs are 0 immediately, with no LdValid pulse.
  - After release, the held LdReq produces a fresh LdGnt one cycle later.
- Back-to-back loader reads of 0x0 and 0x4: LdGnt pulses are MEM_LAT+2=4 cycles apart, and each LdValid carries the matching data word.
